// File: rtl/sram_rmw_bridge.sv
// Bridge from the CPU SRAM-like bus to a word-wide async-read RAM; byte-strobed
// writes become read-modify-write sequences with an optional emulated latency.
module sram_rmw_bridge #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int DELAY      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {IDLE, WAIT, RD, WR, DONE} state_t;

  localparam logic [7:0] DELAY_CNT = 8'(DELAY);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [3:0]              strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   old_q, old_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   merged;

  // Transfer size and the byte offset do not affect a word-wide RAM; upper bits alias.
  logic unused_inputs;
  assign unused_inputs = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          strb_d  = wstrb;
          wdata_d = wdata;
          idx_d   = addr[ADDR_WIDTH+1:2];
          cnt_d   = DELAY_CNT;
          state_d = (DELAY_CNT != 8'd0) ? WAIT : RD;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = RD;
        end
      end
      RD: begin
        // ram_q is only valid here; the RAM floats its read port once we is raised.
        old_d = ram_q;
        if (wr_q) begin
          rdata_d = '0;
          state_d = WR;
        end else begin
          rdata_d = ram_q;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    merged = old_q;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb_q[b]) begin
        merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
    end
  end

  assign addr_ok = (state_q == IDLE) && !reset;
  assign data_ok = (state_q == DONE);
  assign ram_we  = (state_q == WR);
  assign ram_a   = idx_q;
  assign ram_d   = merged;
  assign rdata   = rdata_q;

endmodule

// File: doc/sram_rmw_bridge.md
# sram_rmw_bridge

Bridge between the CPU's SRAM-like data bus (req/addr_ok/data_ok handshake) and the word-wide asynchronous-read RAM used in the SoC simulation environment. It sits directly upstream of the data RAM and drives its clk/we/a/d pins. It turns byte-strobed CPU writes into read-modify-write sequences, because the RAM has only a full-word write enable and tri-states its read port while `we` is high. A configurable delay emulates memory latency for verification.

## Interface
- ADDR_WIDTH, 14, RAM word-address width.
- DATA_WIDTH, 32, word width; fixed at 32 because `wstrb` is 4 bits.
- DELAY, 0, extra wait cycles inserted between accept and the RAM access; legal range 0–255.

- clk  input  1  single clock for bridge and RAM.
- reset  input  1  synchronous, active-high reset.
- req  input  1  CPU request valid.
- wr  input  1  1 = write, 0 = read.
- size  input  2  transfer size; informational only, `wstrb` governs the merge.
- wstrb  input  4  byte enables for writes; bit i covers byte i.
- addr  input  32  byte address; only addr[ADDR_WIDTH+1:2] is used.
- wdata  input  32  write data.
- addr_ok  output  1  request accepted this cycle when `req` is also high.
- data_ok  output  1  one-cycle completion pulse.
- rdata  output  32  read data; valid while `data_ok` is high.
- ram_we  output  1  RAM write enable.
- ram_a  output  ADDR_WIDTH  RAM word address.
- ram_d  output  32  RAM write data.
- ram_q  input  32  RAM asynchronous read data; Z while `ram_we` is high.

## Operation
- FSM states: IDLE, WAIT, RD, WR, DONE.
- IDLE:
  - `addr_ok` = 1 (forced to 0 while `reset` is high).
  - On `req && addr_ok`, latch wr, wstrb, wdata and the word index.
  - Load the counter with DELAY, then go to WAIT if DELAY > 0, otherwise to RD.
- WAIT: decrement the counter each cycle; go to RD when the counter reaches 1.
- RD:
  - `ram_we` = 0.
  - Capture `ram_q` into the old-word register.
  - Read: `rdata` register <= `ram_q`, then go to DONE.
  - Write: go to WR.
- WR:
  - `ram_we` = 1.
  - `ram_d` byte i = wstrb[i] ? wdata byte i : old-word byte i.
  - Go to DONE.
  - `wstrb` = 0 is legal: the RAM rewrites the old word unchanged.
- DONE: `data_ok` = 1 for exactly one cycle, then back to IDLE.
- At most one transaction is outstanding; `addr_ok` is 0 in every state except IDLE.
- `ram_a` is driven from the latched index in all states, so it is stable from the cycle after accept through DONE.
- `ram_q` is sampled only in RD, never while `ram_we` = 1.
- Upper address bits above ADDR_WIDTH+1 are ignored, so addresses alias.
- `rdata` holds its last value outside DONE. After a write it is 0.

## Timing
- E0 is the accept edge; cycle n is the n-th cycle after E0.
- Read: RD in cycle DELAY+1; `data_ok` in cycle DELAY+2.
- Write: RD in cycle DELAY+1; WR (`ram_we`=1) in cycle DELAY+2; RAM updates at the end of that cycle; `data_ok` in cycle DELAY+3.
- Next accept is possible in cycle DELAY+3 for reads and DELAY+4 for writes. `req` held high through DONE is not accepted during DONE.
- Reset values: state IDLE, `addr_ok`=0 while reset is high and 1 afterwards, `data_ok`=0, `ram_we`=0, `rdata`=0, `ram_a`=0, `ram_d`=0, counter=0.
- Reset asserted mid-transaction:
  - Next state is IDLE.
  - No `ram_we` pulse is issued after the reset edge, and no `data_ok` is issued.
  - A WR cycle coinciding with the reset cycle still writes, because the RAM samples `we` at that edge.
- Inputs other than `req` are don't-care outside the accept cycle.

## Test plan
- Read, DELAY=0: RAM[5]=0x11223344; req, wr=0, addr=0x14 -> `addr_ok` at E0; `data_ok`=1 with `rdata`=0x11223344 exactly 2 cycles later; `data_ok` low before and after.
- Byte write: RAM[2]=0xAABBCCDD; write addr=0x8, wstrb=4'b0101, wdata=0x11223344 -> `ram_we` high for one cycle with `ram_d`=0xAA22CC44; a follow-up read returns 0xAA22CC44.
- Full and empty strobe: wstrb=4'hF, wdata=0xDEADBEEF -> RAM word becomes 0xDEADBEEF; wstrb=0 -> word unchanged, `data_ok` still pulses.
- DELAY=3: read `data_ok` in cycle 5 and write `data_ok` in cycle 6; `addr_ok` stays 0 while a second `req` is held, and the second request is accepted only in IDLE.
- Back-to-back: write to word 7 then read word 7 with `req` held continuously -> the read returns the new data; exactly one `ram_we` pulse.
- Reset during WAIT of a write (DELAY=4): assert reset in cycle 2 -> no `ram_we`, no `data_ok`; RAM unchanged; `addr_ok`=1 in the first cycle after reset deasserts.
